// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer.
// Holds the FSM state encoding, the spurious/reset priority levels and
// small helpers for priority ranking and one-hot level decoding.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } pic_state_e;

  // Level reported when the request vanishes before the first INTA
  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;
  // lp = 7 makes IR0 the highest priority
  localparam logic [LVL_W-1:0] LP_RESET       = 3'd7;

  // Rank of a level under rotation: 0 is highest priority, 7 lowest
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] level,
                                                 input logic [LVL_W-1:0] lp);
    return LVL_W'(level - lp - 3'd1);
  endfunction

  function automatic logic [NUM_IR-1:0] level_onehot(input logic [LVL_W-1:0] level);
    return NUM_IR'(1) << level;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: returns the highest-priority set bit of vec_i
// where priority runs from lp_i+1 (highest) down to lp_i (lowest), mod 8.
//   vec_i   : request vector
//   lp_i    : current lowest-priority level
//   valid_o : any bit of vec_i set
//   level_o : winning level (0 when no bit set)
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  logic [LVL_W-1:0]  lp_i,
  output logic              valid_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [LVL_W-1:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    valid_o = 1'b0;
    level_o = '0;
    idx     = '0;
    for (int i = NUM_IR; i >= 1; i--) begin
      idx = LVL_W'(lp_i + LVL_W'(i));
      if (vec_i[idx]) begin
        valid_o = 1'b1;
        level_o = idx;
      end
    end
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer with fully nested, rotating
// priority and in-service tracking.
//   clk, rst_n    : clock, async active-low reset
//   irr, imr      : pending requests and mask (1 = masked)
//   inta_n        : acknowledge strobe, already synchronous to clk
//   vec_base      : upper five vector bits
//   eoi_req/...   : one-cycle EOI command with specific/level/rotate qualifiers
//   int_out       : interrupt request to the CPU
//   isr           : in-service register
//   irr_clr       : one-cycle clear pulse for the serviced request
//   data_out/oe   : vector byte and its drive enable during the second INTA
// Build option PIC_AEOI_EN: the inta_n rise ending the second acknowledge
// clears the serviced isr bit automatically (and rotates on eoi_rotate).
module pic_ack_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic [4:0] vec_base,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irr_clr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  pic_state_e        state_q, state_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [LVL_W-1:0]  lp_q, lp_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              spur_q, spur_d;
  logic              rise_seen_q, rise_seen_d;
  logic              inta_prev_q;
  logic              int_out_q, int_out_d;
  logic [NUM_IR-1:0] irr_clr_q, irr_clr_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;

  logic [NUM_IR-1:0] cand;
  logic              cand_valid, isr_valid, req_valid;
  logic [LVL_W-1:0]  cand_level, isr_top;
  logic              inta_fall, inta_rise;
  logic [NUM_IR-1:0] set_mask, eoi_clr, aeoi_clr;
  logic              eoi_rot_en, aeoi_rot_en;
  logic [LVL_W-1:0]  eoi_lvl;

  assign cand      = irr & ~imr;
  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  pic_priority_resolver u_cand_res (
    .vec_i   (cand),
    .lp_i    (lp_q),
    .valid_o (cand_valid),
    .level_o (cand_level)
  );

  pic_priority_resolver u_isr_res (
    .vec_i   (isr_q),
    .lp_i    (lp_q),
    .valid_o (isr_valid),
    .level_o (isr_top)
  );

  // Fully nested: a candidate counts only if it outranks everything in service
  assign req_valid = cand_valid &&
                     (!isr_valid || (prio_rank(cand_level, lp_q) < prio_rank(isr_top, lp_q)));

  // Acknowledge FSM next-state and output decode
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    spur_d      = spur_q;
    rise_seen_d = rise_seen_q;
    set_mask    = '0;
    aeoi_clr    = '0;
    aeoi_rot_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_PEND;
          level_d = cand_level;
        end
      end
      ST_PEND: begin
        // Follow the live winner until the first INTA fall commits it
        if (req_valid) level_d = cand_level;
        if (inta_fall) begin
          state_d     = ST_ACK1;
          rise_seen_d = 1'b0;
          if (req_valid) begin
            spur_d   = 1'b0;
            set_mask = level_onehot(cand_level);
          end else begin
            spur_d  = 1'b1;
            level_d = SPURIOUS_LEVEL;
          end
        end
      end
      ST_ACK1: begin
        if (inta_rise) begin
          rise_seen_d = 1'b1;
        end else if (inta_fall && rise_seen_q) begin
          state_d = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          state_d = ST_IDLE;
`ifdef PIC_AEOI_EN
          if (!spur_q) begin
            aeoi_clr    = level_onehot(level_q);
            aeoi_rot_en = eoi_rotate;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    int_out_d  = (state_d == ST_PEND);
    irr_clr_d  = set_mask;
    data_oe_d  = (state_d == ST_ACK2);
    data_out_d = data_oe_d ? {vec_base, level_d} : 8'h00;
  end

  // EOI decode; non-specific EOI targets the top in-service level
  always_comb begin
    eoi_clr    = '0;
    eoi_lvl    = '0;
    eoi_rot_en = 1'b0;
    if (eoi_req) begin
      if (eoi_specific) begin
        eoi_clr    = level_onehot(eoi_level);
        eoi_lvl    = eoi_level;
        eoi_rot_en = eoi_rotate;
      end else if (isr_valid) begin
        eoi_clr    = level_onehot(isr_top);
        eoi_lvl    = isr_top;
        eoi_rot_en = eoi_rotate;
      end
    end
  end

  // Clears act on the old isr; a simultaneous set still lands
  always_comb begin
    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | set_mask;
    lp_d  = lp_q;
    if (eoi_rot_en) begin
      lp_d = eoi_lvl;
    end else if (aeoi_rot_en) begin
      lp_d = level_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      isr_q       <= '0;
      lp_q        <= LP_RESET;
      level_q     <= '0;
      spur_q      <= 1'b0;
      rise_seen_q <= 1'b0;
      inta_prev_q <= 1'b1;
      int_out_q   <= 1'b0;
      irr_clr_q   <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      lp_q        <= lp_d;
      level_q     <= level_d;
      spur_q      <= spur_d;
      rise_seen_q <= rise_seen_d;
      inta_prev_q <= inta_n;
      int_out_q   <= int_out_d;
      irr_clr_q   <= irr_clr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign int_out  = int_out_q;
  assign isr      = isr_q;
  assign irr_clr  = irr_clr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed plus randomized bench for pic_ack_sequencer with a rank-based
// reference model of isr, lp and request arbitration.
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr, imr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       eoi_req, eoi_specific, eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_out, data_oe;
  logic [7:0] isr, irr_clr, data_out;

  int total = 0;
  int bad   = 0;
  int m_isr = 0;
  int m_lp  = 7;

  always #5 clk = ~clk;

  pic_ack_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr          (irr),
    .imr          (imr),
    .inta_n       (inta_n),
    .vec_base     (vec_base),
    .eoi_req      (eoi_req),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .eoi_rotate   (eoi_rotate),
    .int_out      (int_out),
    .isr          (isr),
    .irr_clr      (irr_clr),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = highest priority under the current lowest-priority level
  function automatic int rank_of(input int lvl, input int lp);
    return (lvl - lp - 1 + 16) % 8;
  endfunction

  function automatic int top_of(input int vec, input int lp);
    int best = -1;
    for (int l = 0; l < 8; l++)
      if (vec[l] && (best < 0 || rank_of(l, lp) < rank_of(best, lp))) best = l;
    return best;
  endfunction

  function automatic int want();
    int w, s;
    w = top_of(int'(irr & ~imr), m_lp);
    s = top_of(m_isr, m_lp);
    if (w < 0) return -1;
    if (s >= 0 && rank_of(w, m_lp) >= rank_of(s, m_lp)) return -1;
    return w;
  endfunction

  task automatic model_eoi(input bit spec, input int lvl, input bit rot);
    int t;
    if (spec) begin
      m_isr = m_isr & ~(1 << lvl);
      if (rot) m_lp = lvl;
    end else begin
      t = top_of(m_isr, m_lp);
      if (t >= 0) begin
        m_isr = m_isr & ~(1 << t);
        if (rot) m_lp = t;
      end
    end
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
    irr          = '0;
    eoi_req      = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    eoi_rotate   = rot;
    step();
    eoi_req      = 1'b0;
    model_eoi(spec, int'(lvl), rot);
    eoi_rotate   = 1'b0;
    chk("eoi_isr", 16'(isr), 16'(m_isr));
  endtask

  // Full two-pulse acknowledge; DUT must be pending on entry
  task automatic do_ack(input bit drop, input logic [7:0] raise, input bit eoi_ns);
    int lvl;
    bit spur;
    chk("pend_int", 16'(int_out), 16'(1));
    if (drop) begin
      irr = '0;
      step();
    end
    if (raise != 8'h00) begin
      irr = irr | raise;
      step();
    end
    lvl  = want();
    spur = (lvl < 0);
    if (spur) lvl = 7;
    inta_n = 1'b0;
    if (eoi_ns) begin
      eoi_req      = 1'b1;
      eoi_specific = 1'b0;
    end
    step();
    eoi_req = 1'b0;
    if (eoi_ns) model_eoi(1'b0, 0, eoi_rotate);
    if (!spur) m_isr = m_isr | (1 << lvl);
    chk("ack1_isr", 16'(isr), 16'(m_isr));
    chk("ack1_irr_clr", 16'(irr_clr), spur ? 16'(0) : 16'(1 << lvl));
    chk("ack1_int", 16'(int_out), 16'(0));
    if (!spur) irr = irr & ~8'(1 << lvl);
    step();
    chk("irr_clr_end", 16'(irr_clr), 16'(0));
    inta_n = 1'b1;
    step();
    step();
    inta_n = 1'b0;
    step();
    chk("ack2_oe", 16'(data_oe), 16'(1));
    chk("ack2_vec", 16'(data_out), 16'({vec_base, 3'(lvl)}));
    step();
    chk("ack2_oe_hold", 16'(data_oe), 16'(1));
    inta_n = 1'b1;
    irr    = '0;
    step();
`ifdef PIC_AEOI_EN
    if (!spur) begin
      m_isr = m_isr & ~(1 << lvl);
      if (eoi_rotate) m_lp = lvl;
    end
`endif
    chk("ack_end_oe", 16'(data_oe), 16'(0));
    chk("ack_end_isr", 16'(isr), 16'(m_isr));
    chk("ack_end_int", 16'(int_out), 16'(0));
  endtask

  // Present a request; acknowledge it if the model says it should fire
  task automatic offer(input logic [7:0] irr_v, input logic [7:0] imr_v, input bit drop,
                       input logic [7:0] raise, input bit eoi_ns);
    bit e;
    irr = irr_v;
    imr = imr_v;
    step();
    e = (want() >= 0);
    chk("int_req", 16'(int_out), 16'(e));
    if (e) do_ack(drop, raise, eoi_ns);
    else irr = '0;
    imr = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    irr          = '0;
    imr          = '0;
    inta_n       = 1'b1;
    vec_base     = 5'h11;
    eoi_req      = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = '0;
    eoi_rotate   = 1'b0;
    #1;
    chk("rst_int", 16'(int_out), 16'(0));
    chk("rst_isr", 16'(isr), 16'(0));
    chk("rst_irr_clr", 16'(irr_clr), 16'(0));
    chk("rst_dout", 16'(data_out), 16'(0));
    chk("rst_oe", 16'(data_oe), 16'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // IR2 beats IR5 with IR0 highest
    offer(8'h24, 8'h00, 1'b0, 8'h00, 1'b0);
    // Lower priority than in-service is held off, higher one nests
    offer(8'h08, 8'h00, 1'b0, 8'h00, 1'b0);
    offer(8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
    // Request withdrawn before first INTA gives the spurious vector
    offer(8'h10, 8'h00, 1'b1, 8'h00, 1'b0);
    // Build isr=0x05, rotate on non-specific EOI, then IR1 wins
    do_eoi(1'b1, 3'd1, 1'b0);
    offer(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
    do_eoi(1'b0, 3'd0, 1'b1);
    offer(8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
    // Higher-priority arrival while pending takes over
    do_eoi(1'b0, 3'd0, 1'b0);
    do_eoi(1'b0, 3'd0, 1'b0);
    do_eoi(1'b0, 3'd0, 1'b0);
    offer(8'h40, 8'h00, 1'b0, 8'h08, 1'b0);
    // EOI coinciding with the in-service set
    offer(8'h02, 8'h00, 1'b0, 8'h00, 1'b1);
    // Masked request is ignored
    offer(8'h80, 8'h80, 1'b0, 8'h00, 1'b0);

    // Reset between the two INTA pulses
    irr = 8'h20;
    step();
    chk("mid_int", 16'(int_out), 16'(want() >= 0));
    inta_n = 1'b0;
    step();
    irr    = '0;
    inta_n = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_int", 16'(int_out), 16'(0));
    chk("mid_rst_isr", 16'(isr), 16'(0));
    chk("mid_rst_oe", 16'(data_oe), 16'(0));
    chk("mid_rst_dout", 16'(data_out), 16'(0));
    step();
    rst_n = 1'b1;
    m_isr = 0;
    m_lp  = 7;
    step();
    chk("post_rst_irr_clr", 16'(irr_clr), 16'(0));
    step();
    chk("post_rst_int", 16'(int_out), 16'(0));
    chk("post_rst_irr_clr2", 16'(irr_clr), 16'(0));
    // lp back to 7: IR0 outranks IR7
    offer(8'h81, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end else begin
        eoi_rotate = 1'($urandom_range(0, 1));
        offer(8'($urandom), 8'($urandom & $urandom), ($urandom_range(0, 4) == 0),
              8'h00, ($urandom_range(0, 3) == 0));
        eoi_rotate = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic_ack_sequencer.md
PIC_ACK_SEQUENCER -- requirements
Module: pic_ack_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port irr, input, 8 bits: request status from the IRQ capture block.
REQ-005 SHALL have port imr, input, 8 bits: mask register; 1 = masked.
REQ-006 SHALL have port inta_n, input, 1 bit: acknowledge strobe, pre-synchronised to clk.
REQ-007 SHALL have port vec_base, input, 5 bits: ICW2 T7..T3.
REQ-008 SHALL have port eoi_req, input, 1 bit: one-cycle OCW2 EOI command pulse.
REQ-009 SHALL have port eoi_specific, input, 1 bit: 1 = specific EOI.
REQ-010 SHALL have port eoi_level, input, 3 bits: level for a specific EOI.
REQ-011 SHALL have port eoi_rotate, input, 1 bit: rotate priority on this EOI.
REQ-012 SHALL have output int_out, 1 bit: interrupt request to the CPU.
REQ-013 SHALL have output isr, 8 bits: in-service register.
REQ-014 SHALL have output irr_clr, 8 bits: one-cycle clear pulse to the IRQ block.
REQ-015 SHALL have output data_out, 8 bits: vector byte.
REQ-016 SHALL have output data_oe, 1 bit: data_out valid / bus drive.

Function
REQ-017 SHALL keep lowest-priority register lp (3 bits); priority order SHALL be lp+1 (highest) through lp (lowest), modulo 8.
REQ-018 SHALL form cand = irr & ~imr and pick its highest-priority bit; that bit SHALL count only if it outranks the highest-priority set isr bit (fully nested).
REQ-019 SHALL implement FSM IDLE -> PEND -> ACK1 -> ACK2 -> IDLE.
REQ-020 In IDLE with a valid candidate, SHALL go to PEND and assert int_out the next cycle (1-cycle latency).
REQ-021 In PEND, SHALL detect a falling edge of inta_n and go to ACK1; on entry SHALL latch the winning level, set that isr bit, pulse irr_clr for that bit for one cycle and deassert int_out.
REQ-022 If the candidate disappears before the first inta_n fall, SHALL still go to ACK1 with level 7 (spurious); no isr bit and no irr_clr pulse SHALL result.
REQ-023 ACK1 SHALL wait for inta_n rise, then its next fall to enter ACK2.
REQ-024 In ACK2, data_out SHALL be {vec_base, level}, and data_oe SHALL be high while inta_n is low; on inta_n rise the FSM SHALL return to IDLE.
REQ-025 SHALL handle a non-specific EOI by clearing the highest-priority set isr bit; an EOI with isr == 0 SHALL be ignored.
REQ-026 SHALL handle a specific EOI by clearing isr[eoi_level].
REQ-027 With eoi_rotate high, lp SHALL become the cleared level.
REQ-028 An EOI coinciding with the ACK1 isr set SHALL apply both; the clear SHALL be evaluated against isr before the set.
REQ-029 A higher-priority candidate arriving while in PEND SHALL replace the latched level up to the first inta_n fall.

Reset
REQ-030 On rst_n low, SHALL set: state IDLE, isr 0, lp 7 (IR0 highest), int_out 0, irr_clr 0, data_out 0, data_oe 0, inta edge history 1.
REQ-031 Reset mid-acknowledge SHALL abandon the cycle; no irr_clr pulse SHALL be emitted after release.

Configuration
REQ-032 SHALL provide macro PIC_AEOI_EN; when defined, the inta_n rise ending ACK2 SHALL clear the serviced isr bit (automatic EOI) and SHALL set lp to it if eoi_rotate is high; when undefined, isr SHALL be cleared only by eoi_req.

Structure
REQ-033 Package pic_pkg SHALL hold the FSM state enum, the spurious level constant (7) and the lp reset value (7).
REQ-034 Rotation plus priority encoding SHALL be sub-module pic_priority_resolver (combinational: vector, lp -> valid, level).

Verification
REQ-035 irr=0x24, imr=0, lp=7, two INTA pulses -> int_out high; isr=0x04; irr_clr=0x04 pulse; vector {vec_base,3'd2}.
REQ-036 isr=0x04, irr=0x08 -> int_out stays low; irr=0x02 -> int_out high, IR1 serviced, isr=0x06.
REQ-037 int_out high with irr=0x10, irr drops before the first INTA -> vector level 7, isr unchanged, no irr_clr.
REQ-038 isr=0x05, non-specific EOI with rotate -> isr=0x04, lp=0; then irr=0x03 -> IR1 wins.
REQ-039 rst_n pulsed low between the two INTA pulses -> all outputs 0, lp=7, FSM IDLE.
REQ-040 PIC_AEOI_EN defined, IR5 acknowledged -> isr returns to 0x00 after the second inta_n rise.
